// File: rtl/bsg_dff_reset_en_pipe_pkg.sv
// Shared helpers for the elastic enable-register pipeline.
// Sizes the occupancy counter from the stage count.
package bsg_dff_reset_en_pipe_pkg;

   function automatic int unsigned count_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bsg_dff_reset_en_pipe_stage.sv
// One pipeline slot: valid bit plus enable-gated data register.
// Clear beats load, load beats drain; data only changes on load.
module bsg_dff_reset_en_pipe_stage
   import bsg_dff_reset_en_pipe_pkg::*;
#(
   parameter int                 width_p     = 1,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clr_i,
   input  logic               ld_i,
   input  logic               adv_i,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o
);

   logic               v_d;
   logic               v_q;
   logic [width_p-1:0] data_d;
   logic [width_p-1:0] data_q;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (clr_i) begin
         v_d = 1'b0;
      end else if (ld_i) begin
         v_d    = 1'b1;
         data_d = data_i;
      end else if (adv_i) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_q    <= 1'b0;
         data_q <= reset_val_p;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

   assign v_o    = v_q;
   assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_reset_en_pipe.sv
// Elastic chain of enable registers; bubbles collapse, full rate.
// Holds the advance/ready chain, flush gating and occupancy count.
module bsg_dff_reset_en_pipe
   import bsg_dff_reset_en_pipe_pkg::*;
#(
   parameter int                 width_p     = 1,
   parameter int                 stages_p    = 2,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 v_i,
   input  logic [width_p-1:0]                   data_i,
   output logic                                 ready_o,
   output logic                                 v_o,
   output logic [width_p-1:0]                   data_o,
   input  logic                                 yumi_i,
   input  logic                                 flush_i,
   output logic [count_width(stages_p)-1:0]     count_o
);

   localparam int cnt_w_lp = count_width(stages_p);

   logic [stages_p-1:0] v_r;
   logic [stages_p:0]   busy;
   logic [stages_p:0]   adv;
   logic [stages_p-1:0] ld;
   logic [width_p-1:0]  data_r [stages_p];
   logic [width_p-1:0]  din    [stages_p];
   logic                acc;
   logic                yumi_eff;

   // The consumer acts as an always-occupied slot past the last stage,
   // so the last stage only drains on yumi.
   always_comb begin
      busy           = {1'b1, v_r};
      adv            = '0;
      adv[stages_p]  = yumi_i & ~flush_i;
      for (int k = stages_p - 1; k >= 0; k--) begin
         adv[k] = ~flush_i & v_r[k] & (~busy[k+1] | adv[k+1]);
      end
   end

   assign yumi_eff = adv[stages_p];
   assign ready_o  = ~flush_i & (~v_r[0] | adv[0]);
   assign acc      = v_i & ready_o;

   for (genvar k = 0; k < stages_p; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign ld[k]  = acc;
         assign din[k] = data_i;
      end else begin : g_body
         assign ld[k]  = adv[k-1];
         assign din[k] = data_r[k-1];
      end

      bsg_dff_reset_en_pipe_stage #(
         .width_p     (width_p),
         .reset_val_p (reset_val_p)
      ) u_stage (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .clr_i   (flush_i),
         .ld_i    (ld[k]),
         .adv_i   (adv[k]),
         .data_i  (din[k]),
         .v_o     (v_r[k]),
         .data_o  (data_r[k])
      );
   end

   assign v_o    = v_r[stages_p-1] & ~flush_i;
   assign data_o = data_r[stages_p-1];

   logic [cnt_w_lp-1:0] count_d;
   logic [cnt_w_lp-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (acc & ~yumi_eff) begin
         count_d = count_q + 1'b1;
      end else if (~acc & yumi_eff) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

   // Protocol monitors: a stalled offer (outside flush) must persist unchanged.
   logic               hold_d;
   logic               hold_q;
   logic [width_p-1:0] hold_data_d;
   logic [width_p-1:0] hold_data_q;

   always_comb begin
      hold_d      = v_i & ~ready_o & ~flush_i;
      hold_data_d = data_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hold_q      <= 1'b0;
         hold_data_q <= reset_val_p;
      end else begin
         hold_q      <= hold_d;
         hold_data_q <= hold_data_d;
         assert (!(yumi_i && !v_o))
            else $error("yumi_i raised while v_o low");
         assert (!hold_q || (v_i && (data_i == hold_data_q)))
            else $error("v_i/data_i changed before acceptance");
      end
   end

endmodule

// File: tb/tb_bsg_dff_reset_en_pipe.sv
// Directed plus random stimulus against a queue-of-positions model.
// Items march one slot per cycle, never overtaking the item ahead.
module tb_bsg_dff_reset_en_pipe;

   localparam int         W  = 8;
   localparam int         S  = 3;
   localparam logic [7:0] RV = 8'hA5;

   logic         clk;
   logic         reset_i;
   logic         v_i;
   logic [W-1:0] data_i;
   logic         ready_o;
   logic         v_o;
   logic [W-1:0] data_o;
   logic         yumi_i;
   logic         flush_i;
   logic [1:0]   count_o;

   bsg_dff_reset_en_pipe #(
      .width_p     (W),
      .stages_p    (S),
      .reset_val_p (RV)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .flush_i (flush_i),
      .count_o (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int           pos_q[$];
   logic [W-1:0] dat_q[$];
   int           np[$];
   logic [W-1:0] last_data;
   logic         exp_ready;
   logic         exp_v;
   logic         acc;
   logic         held;
   logic [W-1:0] held_data;

   logic         rv;
   logic [W-1:0] rd;
   logic         ry;
   logic         rf;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pos_q.delete();
      dat_q.delete();
      last_data = RV;
      held      = 1'b0;
   endtask

   // Asserts reset between edges and checks the immediate effect.
   task automatic pulse_reset();
      v_i     = 1'b0;
      yumi_i  = 1'b0;
      flush_i = 1'b0;
      reset_i = 1'b1;
      model_reset();
      #1;
      chk("rst_v_o", 32'(v_o), 32'(0));
      chk("rst_data_o", 32'(data_o), 32'(RV));
      chk("rst_ready_o", 32'(ready_o), 32'(1));
      chk("rst_count_o", 32'(count_o), 32'(0));
      @(posedge clk);
      #1 reset_i = 1'b0;
   endtask

   task automatic cycle(input logic v, input logic [W-1:0] d,
                        input logic y, input logic f);
      int   prev;
      int   n;
      logic yeff;
      int   keep_p[$];
      logic [W-1:0] keep_d[$];
      @(negedge clk);
      exp_v = !f && pos_q.size() > 0 && pos_q[0] == S - 1;
      yeff  = y & exp_v;
      v_i     = v;
      data_i  = d;
      yumi_i  = yeff;
      flush_i = f;
      np.delete();
      prev = S;
      for (int i = 0; i < pos_q.size(); i++) begin
         if (f || (i == 0 && yeff)) n = S;
         else n = (pos_q[i] + 1 < prev - 1) ? pos_q[i] + 1 : prev - 1;
         np.push_back(n);
         if (n < S) prev = n;
      end
      exp_ready = !f && prev >= 1;
      acc       = v & exp_ready;
      #1;
      chk("ready_o", 32'(ready_o), 32'(exp_ready));
      chk("v_o", 32'(v_o), 32'(exp_v));
      chk("data_o", 32'(data_o), 32'(last_data));
      chk("count_o", 32'(count_o), 32'(pos_q.size()));
      @(posedge clk);
      for (int i = 0; i < pos_q.size(); i++) begin
         if (np[i] < S) begin
            if (np[i] == S - 1 && pos_q[i] != S - 1) last_data = dat_q[i];
            keep_p.push_back(np[i]);
            keep_d.push_back(dat_q[i]);
         end
      end
      pos_q = keep_p;
      dat_q = keep_d;
      if (acc) begin
         pos_q.push_back(0);
         dat_q.push_back(d);
         if (S == 1) last_data = d;
      end
      held      = v & !acc & !f;
      held_data = d;
   endtask

   task automatic drain();
      for (int g = 0; g < 20 && pos_q.size() > 0; g++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("drain_empty", 32'(pos_q.size()), 32'(0));
   endtask

   initial begin
      reset_i = 1'b0;
      v_i     = 1'b0;
      data_i  = '0;
      yumi_i  = 1'b0;
      flush_i = 1'b0;
      model_reset();
      #3;
      pulse_reset();

      for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
      drain();

      for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'd4, 1'b0, 1'b0);
      cycle(1'b1, 8'd4, 1'b1, 1'b0);
      drain();

      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'hC3, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      drain();

      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'h44, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      drain();

      for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
      drain();

      for (int c = 0; c < 600; c++) begin
         if (c == 300) begin
            @(negedge clk);
            #2;
            pulse_reset();
         end
         rf = ($urandom_range(0, 24) == 0);
         if (held) begin
            rv = 1'b1;
            rd = held_data;
         end else begin
            rv = ($urandom_range(0, 2) != 0);
            rd = 8'($urandom);
         end
         if (c < 300) ry = ($urandom_range(0, 3) == 0);
         else ry = ($urandom_range(0, 3) != 0);
         cycle(rv, rd, ry, rf);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
